module_calc_ctrl: RTL and testbench

MODULE_CALC_CTRL -- requirements
Module: module_calc_ctrl

---
 rtl/calc_pkg.sv | 21 ++
 rtl/module_calc_alu.sv | 37 +++
 rtl/module_calc_ctrl.sv | 140 ++++++++++++++
 tb/tb_module_calc_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and operator encoding for the calculator controller.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_DEL = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_NOP = 4'hF;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        CALC,
        SHOW
    } state_t;

endpackage

// File: rtl/module_calc_alu.sv
// Combinational add/subtract unit: saturating add, sign-magnitude subtract.
module module_calc_alu
    import calc_pkg::*;
#(
    parameter int unsigned RES_W = 14
) (
    input  logic [RES_W-1:0] a,
    input  logic [RES_W-1:0] b,
    input  logic             op,
    output logic [RES_W-1:0] result,
    output logic             neg,
    output logic             overflow
);

    logic [RES_W:0] sum;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = '0;
        neg      = 1'b0;
        overflow = 1'b0;
        if (op == OP_SUB) begin
            if (a >= b) begin
                result = a - b;
            end else begin
                result = b - a;
                neg    = 1'b1;
            end
        end else if (sum[RES_W]) begin
            result   = '1;
            overflow = 1'b1;
        end else begin
            result = sum[RES_W-1:0];
        end
    end

endmodule

// File: rtl/module_calc_ctrl.sv
// Two-operand keypad calculator controller: digit entry, add/subtract, chaining and display.
module module_calc_ctrl
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned RES_W  = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [3:0]                   key_code,
    input  logic                         key_valid,
    output logic                         key_ready,
    output logic [RES_W-1:0]             disp_value,
    output logic                         disp_neg,
    output logic                         result_valid,
    output logic                         overflow,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

    localparam int unsigned CNT_W = $clog2(DIGITS + 1);

    state_t           state;
    logic [RES_W-1:0] a, b, result;
    logic             op;

    logic [RES_W-1:0] operand, operand_mul, operand_div;
    logic [RES_W-1:0] alu_result;
    logic             alu_neg, alu_ovf;
    logic             accept, is_digit, is_op;

    assign key_ready   = (state != CALC);
    assign accept      = key_valid && key_ready;
    assign is_digit    = (key_code <= 4'd9);
    assign is_op       = (key_code == KEY_ADD) || (key_code == KEY_SUB);
    // Operand being edited: B only while entering the second operand.
    assign operand     = (state == ENTER_B) ? b : a;
    assign operand_mul = (operand << 3) + (operand << 1) + RES_W'(key_code);
    assign operand_div = operand / RES_W'(10);

    module_calc_alu #(
        .RES_W (RES_W)
    ) u_alu (
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (alu_result),
        .neg      (alu_neg),
        .overflow (alu_ovf)
    );

    always_comb begin
        disp_value = a;
        case (state)
            ENTER_B: disp_value = b;
            CALC:    disp_value = alu_result;
            SHOW:    disp_value = result;
            default: disp_value = a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ENTER_A;
            a            <= '0;
            b            <= '0;
            result       <= '0;
            op           <= OP_ADD;
            digit_cnt    <= '0;
            disp_neg     <= 1'b0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (accept && key_code == KEY_CLR) begin
                state     <= ENTER_A;
                a         <= '0;
                b         <= '0;
                result    <= '0;
                digit_cnt <= '0;
                disp_neg  <= 1'b0;
                overflow  <= 1'b0;
            end else begin
                case (state)
                    ENTER_A, ENTER_B: begin
                        if (accept) begin
                            if (is_digit) begin
                                if (digit_cnt < CNT_W'(DIGITS)) begin
                                    if (state == ENTER_B) b <= operand_mul;
                                    else                  a <= operand_mul;
                                    digit_cnt <= digit_cnt + CNT_W'(1);
                                end
                            end else if (key_code == KEY_DEL) begin
                                if (digit_cnt != '0) begin
                                    if (state == ENTER_B) b <= operand_div;
                                    else                  a <= operand_div;
                                    digit_cnt <= digit_cnt - CNT_W'(1);
                                end
                            end else if (is_op && state == ENTER_A && digit_cnt != '0) begin
                                op        <= (key_code == KEY_SUB);
                                b         <= '0;
                                digit_cnt <= '0;
                                state     <= ENTER_B;
                            end else if (key_code == KEY_EQ && state == ENTER_B &&
                                         digit_cnt != '0) begin
                                state <= CALC;
                            end
                        end
                    end
                    CALC: begin
                        result       <= alu_result;
                        disp_neg     <= alu_neg;
                        overflow     <= alu_ovf;
                        result_valid <= 1'b1;
                        state        <= SHOW;
                    end
                    SHOW: begin
                        if (accept) begin
                            if (is_digit) begin
                                a         <= RES_W'(key_code);
                                digit_cnt <= CNT_W'(1);
                                disp_neg  <= 1'b0;
                                overflow  <= 1'b0;
                                state     <= ENTER_A;
                            end else if (is_op && !disp_neg && !overflow) begin
                                // Chain: the shown result becomes the first operand.
                                a         <= result;
                                op        <= (key_code == KEY_SUB);
                                b         <= '0;
                                digit_cnt <= '0;
                                state     <= ENTER_B;
                            end
                        end
                    end
                    default: state <= ENTER_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_module_calc_ctrl.sv
// Self-checking bench for module_calc_ctrl: scenario tasks plus a result scoreboard.
module tb_module_calc_ctrl;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       key_valid = 1'b0;
    logic       sel11 = 1'b0;
    logic       kv14, kv11;

    logic        kr14, neg14, rv14, ovf14;
    logic [13:0] dv14;
    logic [1:0]  cnt14;
    logic        kr11, neg11, rv11, ovf11;
    logic [10:0] dv11;
    logic [1:0]  cnt11;

    assign kv14 = key_valid & ~sel11;
    assign kv11 = key_valid & sel11;

    module_calc_ctrl dut (
        .clk (clk), .rst_n (rst_n), .key_code (key_code), .key_valid (kv14),
        .key_ready (kr14), .disp_value (dv14), .disp_neg (neg14),
        .result_valid (rv14), .overflow (ovf14), .digit_cnt (cnt14)
    );

    module_calc_ctrl #(.DIGITS (3), .RES_W (11)) dut11 (
        .clk (clk), .rst_n (rst_n), .key_code (key_code), .key_valid (kv11),
        .key_ready (kr11), .disp_value (dv11), .disp_neg (neg11),
        .result_valid (rv11), .overflow (ovf11), .digit_cnt (cnt11)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] v;
        logic        n;
        logic        o;
    } exp_t;

    exp_t q14[$];
    exp_t q11[$];
    exp_t e14, e11;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard: every result_valid pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rv14 === 1'b1) begin
            checks++;
            if (q14.size() == 0) begin
                errors++;
                $display("FAIL sb14_unexpected_pulse got value=%0d want no pulse", dv14);
            end else begin
                e14 = q14.pop_front();
                if ({dv14, neg14, ovf14} !== {e14.v, e14.n, e14.o}) begin
                    errors++;
                    $display("FAIL sb14_result got v=%0d n=%0b o=%0b want v=%0d n=%0b o=%0b",
                             dv14, neg14, ovf14, e14.v, e14.n, e14.o);
                end
            end
        end
        if (rv11 === 1'b1) begin
            checks++;
            if (q11.size() == 0) begin
                errors++;
                $display("FAIL sb11_unexpected_pulse got value=%0d want no pulse", dv11);
            end else begin
                e11 = q11.pop_front();
                if ({dv11, neg11, ovf11} !== {e11.v[10:0], e11.n, e11.o}) begin
                    errors++;
                    $display("FAIL sb11_result got v=%0d n=%0b o=%0b want v=%0d n=%0b o=%0b",
                             dv11, neg11, ovf11, e11.v, e11.n, e11.o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = KEY_NOP;
    endtask

    task automatic keys(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c <= 8'd57) press(4'(c - 8'd48));
            else            press(4'(c - 8'd55));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({dv14, neg14, rv14, ovf14, cnt14, kr14} !== {14'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got dv=%0d n=%0b rv=%0b o=%0b cnt=%0d rdy=%0b want 0,0,0,0,0,1",
                     dv14, neg14, rv14, ovf14, cnt14, kr14);
        end
        rst_n = 1'b1;
        press(4'd4);
        checks++;
        if (dv14 !== 14'd4 || cnt14 !== 2'd1) begin
            errors++;
            $display("FAIL first_key_after_reset got dv=%0d cnt=%0d want 4,1", dv14, cnt14);
        end
    endtask

    task automatic test_add();
        keys("C123A45");
        q14.push_back('{v: 14'd168, n: 1'b0, o: 1'b0});
        press(KEY_EQ);
        checks++;
        if (kr14 !== 1'b0) begin
            errors++;
            $display("FAIL calc_ready got %0b want 0", kr14);
        end
        tick();
        checks++;
        if (rv14 !== 1'b1 || dv14 !== 14'd168 || neg14 !== 1'b0) begin
            errors++;
            $display("FAIL add_show got rv=%0b dv=%0d n=%0b want 1,168,0", rv14, dv14, neg14);
        end
        tick();
        checks++;
        if (rv14 !== 1'b0 || kr14 !== 1'b1) begin
            errors++;
            $display("FAIL pulse_width got rv=%0b rdy=%0b want 0,1", rv14, kr14);
        end
    endtask

    task automatic test_sub();
        keys("12B300");
        q14.push_back('{v: 14'd288, n: 1'b1, o: 1'b0});
        press(KEY_EQ);
        tick();
        checks++;
        if (dv14 !== 14'd288 || neg14 !== 1'b1) begin
            errors++;
            $display("FAIL sub_show got dv=%0d n=%0b want 288,1", dv14, neg14);
        end
        press(KEY_ADD);
        checks++;
        if (dv14 !== 14'd288 || neg14 !== 1'b1 || kr14 !== 1'b1) begin
            errors++;
            $display("FAIL chain_neg_ignored got dv=%0d n=%0b rdy=%0b want 288,1,1",
                     dv14, neg14, kr14);
        end
        keys("DEF");
        repeat (2) tick();
        checks++;
        if (dv14 !== 14'd288 || neg14 !== 1'b1) begin
            errors++;
            $display("FAIL show_def_ignored got dv=%0d n=%0b want 288,1", dv14, neg14);
        end
    endtask

    task automatic test_digits();
        keys("C9999");
        checks++;
        if (dv14 !== 14'd999 || cnt14 !== 2'd3) begin
            errors++;
            $display("FAIL digit_limit got dv=%0d cnt=%0d want 999,3", dv14, cnt14);
        end
        press(KEY_DEL);
        checks++;
        if (dv14 !== 14'd99 || cnt14 !== 2'd2) begin
            errors++;
            $display("FAIL delete got dv=%0d cnt=%0d want 99,2", dv14, cnt14);
        end
        keys("DDD");
        checks++;
        if (dv14 !== 14'd0 || cnt14 !== 2'd0) begin
            errors++;
            $display("FAIL delete_empty got dv=%0d cnt=%0d want 0,0", dv14, cnt14);
        end
        keys("A5E");
        repeat (2) tick();
        checks++;
        if (dv14 !== 14'd5 || cnt14 !== 2'd1 || kr14 !== 1'b1) begin
            errors++;
            $display("FAIL op_empty_and_eq_in_a got dv=%0d cnt=%0d rdy=%0b want 5,1,1",
                     dv14, cnt14, kr14);
        end
    endtask

    task automatic test_drop_in_calc();
        keys("C1A2");
        q14.push_back('{v: 14'd3, n: 1'b0, o: 1'b0});
        press(KEY_EQ);
        press(4'd5);
        checks++;
        if (dv14 !== 14'd3 || neg14 !== 1'b0) begin
            errors++;
            $display("FAIL calc_key_dropped got dv=%0d n=%0b want 3,0", dv14, neg14);
        end
        tick();
        checks++;
        if (dv14 !== 14'd3) begin
            errors++;
            $display("FAIL calc_key_not_buffered got dv=%0d want 3", dv14);
        end
        press(KEY_ADD);
        press(4'd4);
        q14.push_back('{v: 14'd7, n: 1'b0, o: 1'b0});
        press(KEY_EQ);
        tick();
        checks++;
        if (dv14 !== 14'd7) begin
            errors++;
            $display("FAIL chain_add got dv=%0d want 7", dv14);
        end
    endtask

    task automatic test_overflow();
        sel11 = 1'b1;
        keys("C999A999");
        q11.push_back('{v: 14'd1998, n: 1'b0, o: 1'b0});
        press(KEY_EQ);
        tick();
        checks++;
        if (dv11 !== 11'd1998 || ovf11 !== 1'b0) begin
            errors++;
            $display("FAIL sum_1998 got dv=%0d o=%0b want 1998,0", dv11, ovf11);
        end
        keys("A999");
        q11.push_back('{v: 14'd2047, n: 1'b0, o: 1'b1});
        press(KEY_EQ);
        tick();
        checks++;
        if (dv11 !== 11'd2047 || ovf11 !== 1'b1) begin
            errors++;
            $display("FAIL saturate got dv=%0d o=%0b want 2047,1", dv11, ovf11);
        end
        press(KEY_ADD);
        checks++;
        if (dv11 !== 11'd2047 || ovf11 !== 1'b1) begin
            errors++;
            $display("FAIL chain_ovf_ignored got dv=%0d o=%0b want 2047,1", dv11, ovf11);
        end
        press(4'd3);
        checks++;
        if (dv11 !== 11'd3 || ovf11 !== 1'b0 || cnt11 !== 2'd1) begin
            errors++;
            $display("FAIL show_digit got dv=%0d o=%0b cnt=%0d want 3,0,1", dv11, ovf11, cnt11);
        end
        sel11 = 1'b0;
    endtask

    task automatic test_reset_mid();
        keys("C1A7");
        checks++;
        if (dv14 !== 14'd7 || cnt14 !== 2'd1) begin
            errors++;
            $display("FAIL enter_b_value got dv=%0d cnt=%0d want 7,1", dv14, cnt14);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dv14, neg14, rv14, ovf14, cnt14, kr14} !== {14'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset got dv=%0d n=%0b rv=%0b o=%0b cnt=%0d rdy=%0b want 0,0,0,0,0,1",
                     dv14, neg14, rv14, ovf14, cnt14, kr14);
        end
        @(negedge clk);
        rst_n = 1'b1;
        press(4'd4);
        checks++;
        if (dv14 !== 14'd4 || cnt14 !== 2'd1) begin
            errors++;
            $display("FAIL key_after_reset got dv=%0d cnt=%0d want 4,1", dv14, cnt14);
        end
    endtask

    task automatic test_reset_in_calc();
        keys("C1A2");
        press(KEY_EQ);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rv14 !== 1'b0 || kr14 !== 1'b1 || dv14 !== 14'd0) begin
            errors++;
            $display("FAIL calc_abort got rv=%0b rdy=%0b dv=%0d want 0,1,0", rv14, kr14, dv14);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_digits();
        test_drop_in_calc();
        test_overflow();
        test_reset_mid();
        test_reset_in_calc();
        repeat (2) tick();
        checks++;
        if (q14.size() != 0 || q11.size() != 0) begin
            errors++;
            $display("FAIL missing_results got pending14=%0d pending11=%0d want 0,0",
                     q14.size(), q11.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
